// File: rtl/insmem_pkg.sv
// Shared types and helpers for the instruction memory fetch block.
package insmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    // Storage is byte-lane organised; words leave the RAM little-endian.
    function automatic logic [31:0] pack_le(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/insmem_ram.sv
// Word RAM with byte-strobed write port and registered read port.
// Latency: read data valid the cycle after rd_en; writes land at the same edge.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module insmem_ram
    import insmem_pkg::*;
#(
    parameter int NUM_WORDS = 100,
    parameter int IDX_W     = 7
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_dat,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_strb,
    input  logic [31:0]      wr_dat
);

    logic [7:0] mem [NUM_WORDS][4];

    // Read and write share one edge, so a same-word read sees the old contents.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= pack_le(mem[rd_idx][0], mem[rd_idx][1], mem[rd_idx][2], mem[rd_idx][3]);
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i[1:0]]) begin
                    mem[wr_idx][i[1:0]] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/insmem_fetch.sv
// Instruction memory with fetch handshake, run-time program load and post-reset clear.
// Latency: fetch response 1 cycle after acceptance; load visible to the next accepted fetch.
// Backpressure: response held and req_ready low while rsp_valid && !rsp_ready.
module insmem_fetch
    import insmem_pkg::*;
#(
    parameter int DEPTH_BYTES    = 400,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_ins,
    output logic [1:0]        rsp_fault,
    input  logic              rsp_ready,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_strb,
    output logic              busy
);

    localparam int NUM_WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // One extra bit so addresses near the top of the space cannot wrap into range.
    typedef logic [ADDR_W:0] ext_addr_t;
    localparam ext_addr_t LAST_BYTE = ext_addr_t'(DEPTH_BYTES - 4);
    localparam ext_addr_t WORD_MASK = ~ext_addr_t'(3);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_last;

    logic [1:0]       req_fault;
    logic             accept;
    logic             ld_ok;
    logic [1:0]       fault_q;
    logic [31:0]      rd_dat;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_strb;
    logic [31:0]      wr_dat;

    assign clr_last = (clr_idx == IDX_W'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_last) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        busy      = (state == CLEAR);
        req_ready = (state == RUN) && !flush && (!rsp_valid || rsp_ready);
        wr_en     = 1'b0;
        wr_idx    = clr_idx;
        wr_strb   = 4'hF;
        wr_dat    = 32'h0;
        if (state == CLEAR) begin
            wr_en = 1'b1;
        end else begin
            wr_en   = ld_en && ld_ok;
            wr_idx  = ld_addr[IDX_W+1:2];
            wr_strb = ld_strb;
            wr_dat  = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        req_fault                 = 2'b00;
        req_fault[FAULT_MISALIGN] = (req_addr[1:0] != 2'b00);
        req_fault[FAULT_RANGE]    = ({1'b0, req_addr} > LAST_BYTE);
    end

    assign accept = req_valid && req_ready;
    assign ld_ok  = (({1'b0, ld_addr} & WORD_MASK) <= LAST_BYTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            fault_q   <= 2'b00;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            fault_q   <= req_fault;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Faulted fetches never touch storage; their data is forced to zero here.
    assign rsp_fault = rsp_valid ? fault_q : 2'b00;
    assign rsp_ins   = (rsp_valid && fault_q == 2'b00) ? rd_dat : 32'h0;

    insmem_ram #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (accept && (req_fault == 2'b00)),
        .rd_idx  (req_addr[IDX_W+1:2]),
        .rd_dat  (rd_dat),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_strb (wr_strb),
        .wr_dat  (wr_dat)
    );

endmodule

// File: tb/tb_insmem_fetch.sv
// Randomised self-checking bench for insmem_fetch against a byte-array reference model.
module tb_insmem_fetch;

    localparam int DEPTH = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_ins;
    logic [1:0]  rsp_fault;
    logic        rsp_ready;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_strb;
    logic        busy;

    int checks = 0;
    int passes = 0;
    logic [7:0] model [DEPTH];

    always #5 clk = ~clk;

    insmem_fetch #(
        .DEPTH_BYTES    (DEPTH),
        .ADDR_W         (32),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ins   (rsp_ins),
        .rsp_fault (rsp_fault),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_strb   (ld_strb),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passes=%0d", checks, passes);
        $fatal(1, "watchdog");
    end

    // Expected {fault, ins} for a fetch, from the byte-level storage picture.
    function automatic logic [33:0] expect_fetch(input logic [31:0] addr);
        longint unsigned a;
        logic [1:0] f;
        a    = 64'(addr);
        f[0] = (a % 4) != 0;
        f[1] = a > (DEPTH - 4);
        if (f != 2'b00) return {f, 32'h0};
        return {2'b00, model[int'(a) + 3], model[int'(a) + 2], model[int'(a) + 1], model[int'(a)]};
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 99) * 4);
            1:       return 32'($urandom_range(0, DEPTH - 1));
            2:       return 32'($urandom_range(380, 420));
            default: return $urandom();
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    task automatic model_load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        longint unsigned base;
        base = 64'(addr) & ~64'd3;
        if (base <= DEPTH - 4) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model[int'(base) + i] = data[8*i +: 8];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 32'h0;
        ld_data   = 32'h0;
        ld_strb   = 4'h0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        ld_strb = strb;
        cyc();
        ld_en = 1'b0;
        model_load(addr, data, strb);
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] ins,
                            output logic [1:0] fault, output logic vld);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 20 && req_ready !== 1'b1; n++) cyc();
        if (req_ready !== 1'b1) begin
            checks++;
            $display("FAIL fetch_timeout addr=%h req_ready=%b required 1", addr, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ins   = rsp_ins;
        fault = rsp_fault;
        vld   = rsp_valid;
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        drive_idle();
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
        checks++; if (rsp_ins !== 32'h0) $display("FAIL reset_rsp_ins got %h want 0", rsp_ins); else passes++;
        checks++; if (rsp_fault !== 2'b00) $display("FAIL reset_rsp_fault got %b want 00", rsp_fault); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", req_ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else passes++;
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        checks++; if (n != DEPTH / 4) $display("FAIL clear_cycles got %0d want %0d", n, DEPTH / 4); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL ready_after_clear got %b want 1", req_ready); else passes++;
        model_clear();
        do_fetch(32'd396, ins, fault, vld);
        checks++;
        if (vld !== 1'b1 || ins !== 32'h0 || fault !== 2'b00)
            $display("FAIL fetch_top_word got vld=%b ins=%h fault=%b want 1/00000000/00", vld, ins, fault);
        else passes++;
    endtask

    task automatic test_load_fetch();
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        do_load(32'h0, 32'h00200093, 4'hF);
        do_fetch(32'h0, ins, fault, vld);
        checks++;
        if (vld !== 1'b1 || ins !== 32'h00200093 || fault !== 2'b00)
            $display("FAIL load_fetch got vld=%b ins=%h fault=%b want 1/00200093/00", vld, ins, fault);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [33:0] e0, e4;
        do_load(32'h4, $urandom(), 4'hF);
        e0 = expect_fetch(32'h0);
        e4 = expect_fetch(32'h4);
        req_valid = 1'b1;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", req_ready); else passes++;
        @(posedge clk);
        #1;
        req_addr = 32'h4;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ins !== e0[31:0])
            $display("FAIL b2b_rsp0 got vld=%b ins=%h want 1/%h", rsp_valid, rsp_ins, e0[31:0]);
        else passes++;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", req_ready); else passes++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ins !== e4[31:0])
            $display("FAIL b2b_rsp1 got vld=%b ins=%h want 1/%h", rsp_valid, rsp_ins, e4[31:0]);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [33:0] e8, e12;
        do_load(32'd8, $urandom(), 4'hF);
        do_load(32'd12, $urandom(), 4'hF);
        e8  = expect_fetch(32'd8);
        e12 = expect_fetch(32'd12);
        req_valid = 1'b1;
        req_addr  = 32'd8;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_addr = 32'd12;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_ins !== e8[31:0])
                $display("FAIL stall_%0d got rdy=%b vld=%b ins=%h want 0/1/%h", k, req_ready, rsp_valid, rsp_ins, e8[31:0]);
            else passes++;
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL release_ready got %b want 1", req_ready); else passes++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ins !== e12[31:0])
            $display("FAIL after_stall got vld=%b ins=%h want 1/%h", rsp_valid, rsp_ins, e12[31:0]);
        else passes++;
        cyc();
    endtask

    task automatic test_faults();
        logic [31:0] addrs [5];
        logic [1:0]  want  [5];
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        addrs = '{32'h2, 32'd400, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'd397};
        want  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
        for (int i = 0; i < 5; i++) begin
            do_fetch(addrs[i], ins, fault, vld);
            checks++;
            if (vld !== 1'b1 || fault !== want[i] || ins !== 32'h0)
                $display("FAIL fault_%h got vld=%b fault=%b ins=%h want 1/%b/00000000", addrs[i], vld, fault, ins, want[i]);
            else passes++;
        end
    endtask

    task automatic test_partial_load();
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        logic [33:0] e;
        do_load(32'd16, 32'h0, 4'hF);
        do_load(32'd16, 32'h00AB0000, 4'b0100);
        do_fetch(32'd16, ins, fault, vld);
        checks++; if (ins !== 32'h00AB0000) $display("FAIL partial_strb got %h want 00ab0000", ins); else passes++;
        do_load(32'd16, 32'hFFFFFFFF, 4'b0000);
        e = expect_fetch(32'd16);
        do_fetch(32'd16, ins, fault, vld);
        checks++; if (ins !== e[31:0]) $display("FAIL zero_strb got %h want %h", ins, e[31:0]); else passes++;
        do_load(32'd512, 32'hDEADBEEF, 4'hF);
        e = expect_fetch(32'd0);
        do_fetch(32'd0, ins, fault, vld);
        checks++; if (ins !== e[31:0]) $display("FAIL oor_load_dropped got %h want %h", ins, e[31:0]); else passes++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        logic [33:0] e_old, e_new;
        logic [31:0] nv;
        do_load(32'd20, $urandom(), 4'hF);
        e_old = expect_fetch(32'd20);
        nv = ~e_old[31:0];
        req_valid = 1'b1;
        req_addr  = 32'd20;
        rsp_ready = 1'b1;
        ld_en     = 1'b1;
        ld_addr   = 32'd20;
        ld_data   = nv;
        ld_strb   = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ld_en     = 1'b0;
        model_load(32'd20, nv, 4'hF);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ins !== e_old[31:0])
            $display("FAIL rbw_old got vld=%b ins=%h want 1/%h", rsp_valid, rsp_ins, e_old[31:0]);
        else passes++;
        e_new = expect_fetch(32'd20);
        do_fetch(32'd20, ins, fault, vld);
        checks++; if (ins !== e_new[31:0]) $display("FAIL rbw_new got %h want %h", ins, e_new[31:0]); else passes++;
    endtask

    task automatic test_flush();
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        logic [33:0] e;
        req_valid = 1'b1;
        req_addr  = 32'd0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b1;
        req_addr = 32'd4;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", req_ready); else passes++;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL flush_drop got %b want 0", rsp_valid); else passes++;
        flush     = 1'b0;
        req_valid = 1'b0;
        e = expect_fetch(32'd4);
        do_fetch(32'd4, ins, fault, vld);
        checks++;
        if (vld !== 1'b1 || ins !== e[31:0])
            $display("FAIL post_flush got vld=%b ins=%h want 1/%h", vld, ins, e[31:0]);
        else passes++;
    endtask

    task automatic test_reset_midclear();
        int n;
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        do_fetch(32'd0, ins, fault, vld);
        rsp_ready = 1'b0;
        rst = 1'b1;
        cyc();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_drops_rsp got %b want 0", rsp_valid); else passes++;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (50) cyc();
        checks++; if (busy !== 1'b1) $display("FAIL midclear_busy got %b want 1", busy); else passes++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        checks++; if (n != DEPTH / 4) $display("FAIL restart_clear got %0d want %0d", n, DEPTH / 4); else passes++;
        model_clear();
        do_fetch(32'd0, ins, fault, vld);
        checks++; if (ins !== 32'h0 || vld !== 1'b1) $display("FAIL cleared_word got vld=%b ins=%h want 1/0", vld, ins); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [1:0]  fault;
        logic        vld;
        logic [31:0] a;
        logic [33:0] e;
        for (int it = 0; it < 300; it++) begin
            a = rand_addr();
            if ($urandom_range(0, 2) == 0) begin
                do_load(a, $urandom(), 4'($urandom_range(0, 15)));
            end else begin
                e = expect_fetch(a);
                do_fetch(a, ins, fault, vld);
                checks++;
                if (vld !== 1'b1 || ins !== e[31:0] || fault !== e[33:32])
                    $display("FAIL rand_fetch_%h got vld=%b ins=%h fault=%b want 1/%h/%b", a, vld, ins, fault, e[31:0], e[33:32]);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_backpressure();
        test_faults();
        test_partial_load();
        test_same_cycle();
        test_flush();
        test_reset_midclear();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
